dbus_shadow_mem: RTL and testbench
==================================

// Module: dbus_shadow_mem
// PURPOSE
// - Parametrised data-bus memory model for formal and simulation benches of cmd/rsp cores.
// - Shadows NSLOTS word addresses with byte-accurate contents and queues up to RSP_DEPTH outstanding reads.
// - Read data comes from shadowed bytes once written, else from free (solver-chosen) data.
// - Sits between core dBus and rvfi_dmem_check; replaces single-address, single-outstanding models.
// PARAMETERS
// - XLEN       32  data/address width; 32 or 64; bytes per word NB = XLEN/8
// - NSLOTS     2   number of independently tracked word addresses (>=1)
// - RSP_DEPTH  4   max outstanding read responses (power of 2, >=2)
// PORTS
// - clk            in   1              clock, rising edge
// - resetn         in   1              asynchronous, active-low reset
// - slot_addr      in   NSLOTS*XLEN    tracked addresses; word index = addr>>log2(NB); held constant by bench
// - cmd_valid      in   1              core command valid
// - cmd_ready      out  1              command accepted when cmd_valid && cmd_ready
// - cmd_wr         in   1              1 = store, 0 = load
// - cmd_address    in   XLEN           byte address
// - cmd_data       in   XLEN           store data, byte lanes aligned to word
// - cmd_size       in   2              log2 bytes: 0=B,1=H,2=W,3=D (D only when XLEN=64)
// - cmd_stall      in   1              free input; forces cmd_ready low
// - rsp_valid      out  1              read response valid
// - rsp_hold       in   1              free input; forces rsp_valid low (models bus latency)
// - rsp_data       out  XLEN           read response data
// - free_data      in   XLEN           free data used for untracked/unwritten bytes
// - cmd_misaligned out  1              registered flag: accepted cmd crossed a word boundary
// - fifo_full      out  1              RSP_DEPTH reads outstanding
// BEHAVIOUR
// - Reset (resetn low, async): FIFO empty, all slot byte-valid bits 0, cmd_misaligned 0; cmd_ready, rsp_valid 0.
// - Reset mid-operation: outstanding reads are dropped, never responded to; shadowed contents lost.
// - cmd_ready = !cmd_stall && !(fifo_full && !cmd_wr); stores are never blocked by a full FIFO.
// - mask = ((1<<(1<<size))-1) << addr[log2(NB)-1:0], truncated to NB bits; bits beyond NB set cmd_misaligned next cycle.
// - Misaligned accepted cmds: stores write only in-word bytes; loads still enqueue one response.
// - Store accept: every slot whose word index matches writes masked bytes and sets their byte-valid bits; duplicate slot addresses all update.
// - Load accept: data captured THAT cycle: per byte, slot byte if matching slot and byte-valid, else free_data byte.
// - Captured data pushed to FIFO; later stores never alter a queued response.
// - Simultaneous store and load cannot occur (one cmd per cycle).
// - Store to word in same cycle a load to it is popped: popped data unaffected.
// - rsp_valid = !fifo_empty && !rsp_hold; no rsp_ready: the response is consumed the cycle rsp_valid is high.
// - rsp_data = FIFO head, whole word; core selects lanes.
// - Latency: load accepted at cycle N -> earliest rsp_valid at N+1.
// - Push and pop same cycle: count unchanged, allowed even when full.
// - Pointers wrap modulo RSP_DEPTH; count width log2(RSP_DEPTH)+1.
// - rsp_valid with empty FIFO and push into full FIFO are impossible by construction; both carry immediate asserts.
// STRUCTURE
// - Package dbus_shadow_pkg: size enum (SZ_B..SZ_D), function size_mask(size, offset, NB) returning 2*NB-bit mask.
// - Sub-module dbus_rsp_fifo: RSP_DEPTH x XLEN sync FIFO, push/pop/full/empty/count, async active-low reset.
// - Top: slot array (NSLOTS x (XLEN data + NB valid)), match/merge logic, misaligned flag register.
// TESTING
// - Store W 0xDEADBEEF to slot0 addr 0x100, load W 0x100 -> rsp_data 0xDEADBEEF one cycle after accept.
// - Store B 0xAA to 0x102, load W 0x100, free_data 0x11223344 -> rsp_data 0x11AA3344.
// - Store W 0x1 to 0x100, load 0x100, store W 0x2 to 0x100 before rsp, rsp_hold high 3 cycles -> rsp_data 0x1.
// - RSP_DEPTH=4, rsp_hold high, 4 loads -> fifo_full 1, cmd_ready 0 for load, store still accepted; release -> 4 in-order responses.
// - Store H at 0x103 -> cmd_misaligned 1 next cycle, only byte 3 of slot word written.
// - resetn low with 2 queued loads -> rsp_valid 0 immediately, FIFO empty, later loads return free_data.

Source files
------------

// File: rtl/dbus_shadow_pkg.sv
// Shared types and helpers for the shadowed data-bus memory model.
package dbus_shadow_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  // Wide enough for a double access at the largest offset of a 64-bit word.
  localparam int MASK_W = 16;

  // Byte-enable mask of an access, spanning two words so that lanes falling
  // beyond the addressed word remain visible for misalignment detection.
  function automatic logic [MASK_W-1:0] size_mask(input logic [1:0] size,
                                                  input logic [2:0] offset,
                                                  input int         nb);
    logic [MASK_W-1:0] base;
    logic [MASK_W-1:0] m;
    case (size_e'(size))
      SZ_B:    base = 16'h0001;
      SZ_H:    base = 16'h0003;
      SZ_W:    base = 16'h000F;
      SZ_D:    base = 16'h00FF;
      default: base = 16'h0000;
    endcase
    m = base << offset;
    for (int i = 0; i < MASK_W; i++) begin
      if (i >= 2 * nb) m[i] = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/dbus_rsp_fifo.sv
// Synchronous response FIFO holding read data captured at load acceptance.
module dbus_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Pointer and occupancy update; pointers wrap naturally at the power-of-2 depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_i && !pop_i) count_d = count_q + 1'b1;
    if (pop_i && !push_i) count_d = count_q - 1'b1;
  end

  // Control state; reset drops every queued entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;

  // Underflow and overflow cannot happen given the producer/consumer gating.
  always @(posedge clk) begin
    if (resetn) begin
      assert (!(pop_i && empty_o));
      assert (!(push_i && full_o && !pop_i));
    end
  end

endmodule

// File: rtl/dbus_shadow_mem.sv
// Data-bus memory model: byte-accurate shadow of a few tracked words plus
// a queue of outstanding read responses.
module dbus_shadow_mem
  import dbus_shadow_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NSLOTS    = 2,
  parameter int RSP_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NSLOTS*XLEN-1:0] slot_addr,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_wr,
  input  logic [XLEN-1:0]        cmd_address,
  input  logic [XLEN-1:0]        cmd_data,
  input  logic [1:0]             cmd_size,
  input  logic                   cmd_stall,
  output logic                   rsp_valid,
  input  logic                   rsp_hold,
  output logic [XLEN-1:0]        rsp_data,
  input  logic [XLEN-1:0]        free_data,
  output logic                   cmd_misaligned,
  output logic                   fifo_full
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CW   = $clog2(RSP_DEPTH) + 1;

  logic [XLEN-1:0]   slot_data_q [NSLOTS];
  logic [XLEN-1:0]   slot_data_d [NSLOTS];
  logic [NB-1:0]     slot_vld_q  [NSLOTS];
  logic [NB-1:0]     slot_vld_d  [NSLOTS];
  logic [NSLOTS-1:0] slot_hit;
  logic [MASK_W-1:0] mask_all;
  logic [2*NB-1:0]   mask_2w;
  logic [NB-1:0]     byte_mask;
  logic              misaligned;
  logic [XLEN-1:0]   load_data;
  logic              accept, push, fifo_empty;
  logic              cmd_misaligned_q, cmd_misaligned_d;
  logic [CW-1:0]     fifo_count;
  logic              unused_bits;

  // Loads are refused only when there is nowhere to queue their response.
  assign cmd_ready = resetn && !cmd_stall && !(fifo_full && !cmd_wr);
  assign accept    = cmd_valid && cmd_ready;
  assign push      = accept && !cmd_wr;
  assign rsp_valid = !fifo_empty && !rsp_hold;

  // Byte lanes touched by the command; lanes past the word flag misalignment.
  always_comb begin
    mask_all   = size_mask(cmd_size, 3'(cmd_address[OFFW-1:0]), NB);
    mask_2w    = mask_all[2*NB-1:0];
    byte_mask  = mask_2w[NB-1:0];
    misaligned = |mask_2w[2*NB-1:NB];
  end

  // Word-index match of the command against each tracked address.
  always_comb begin
    slot_hit = '0;
    for (int s = 0; s < NSLOTS; s++) begin
      slot_hit[s] = (slot_addr[s*XLEN+OFFW +: XLEN-OFFW] == cmd_address[XLEN-1:OFFW]);
    end
  end

  // Store merge into every matching slot and load-data capture from the
  // current (pre-store) shadow contents.
  always_comb begin
    slot_data_d = slot_data_q;
    slot_vld_d  = slot_vld_q;
    load_data   = free_data;
    for (int s = 0; s < NSLOTS; s++) begin
      for (int b = 0; b < NB; b++) begin
        if (slot_hit[s] && slot_vld_q[s][b]) begin
          load_data[8*b +: 8] = slot_data_q[s][8*b +: 8];
        end
        if (accept && cmd_wr && slot_hit[s] && byte_mask[b]) begin
          slot_data_d[s][8*b +: 8] = cmd_data[8*b +: 8];
          slot_vld_d[s][b]         = 1'b1;
        end
      end
    end
    cmd_misaligned_d = accept && misaligned;
  end

  // Shadow contents and misalignment flag; reset forgets everything written.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      slot_data_q      <= '{default: '0};
      slot_vld_q       <= '{default: '0};
      cmd_misaligned_q <= 1'b0;
    end else begin
      slot_data_q      <= slot_data_d;
      slot_vld_q       <= slot_vld_d;
      cmd_misaligned_q <= cmd_misaligned_d;
    end
  end

  assign cmd_misaligned = cmd_misaligned_q;

  dbus_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (XLEN)
  ) u_rsp_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (push),
    .pop_i   (rsp_valid),
    .wdata_i (load_data),
    .rdata_o (rsp_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Address offsets of tracked slots and the occupancy count are not needed here.
  assign unused_bits = ^{slot_addr, fifo_count, mask_all};

endmodule

// File: tb/tb_dbus_shadow_mem.sv
module tb_dbus_shadow_mem;

  logic        clk;
  logic        resetn;
  logic [63:0] slot_addr;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [31:0] cmd_address;
  logic [31:0] cmd_data;
  logic [1:0]  cmd_size;
  logic        cmd_stall;
  logic        rsp_valid;
  logic        rsp_hold;
  logic [31:0] rsp_data;
  logic [31:0] free_data;
  logic        cmd_misaligned;
  logic        fifo_full;

  int n_checks = 0;
  int n_fail   = 0;

  dbus_shadow_mem #(
    .XLEN      (32),
    .NSLOTS    (2),
    .RSP_DEPTH (4)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .slot_addr      (slot_addr),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_wr         (cmd_wr),
    .cmd_address    (cmd_address),
    .cmd_data       (cmd_data),
    .cmd_size       (cmd_size),
    .cmd_stall      (cmd_stall),
    .rsp_valid      (rsp_valid),
    .rsp_hold       (rsp_hold),
    .rsp_data       (rsp_data),
    .free_data      (free_data),
    .cmd_misaligned (cmd_misaligned),
    .fifo_full      (fifo_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One command presented for exactly one clock; returns 1 time unit after the edge.
  task automatic issue(input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [1:0] size);
    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_wr      = wr;
    cmd_address = addr;
    cmd_data    = data;
    cmd_size    = size;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
    n_checks++; if (fifo_full !== 1'b0) begin n_fail++; $display("FAIL reset_fifo_full: got %b want 0", fifo_full); end
    n_checks++; if (cmd_misaligned !== 1'b0) begin n_fail++; $display("FAIL reset_misaligned: got %b want 0", cmd_misaligned); end
    @(negedge clk);
    resetn = 1'b1;
    #1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_cmd_ready: got %b want 1", cmd_ready); end
    cmd_stall = 1'b1;
    #1;
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL stall_cmd_ready: got %b want 0", cmd_ready); end
    cmd_stall = 1'b0;
  endtask

  task automatic test_store_load();
    free_data = 32'h0;
    issue(1'b1, 32'h100, 32'hDEADBEEF, 2'd2);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL store_no_rsp: got %b want 0", rsp_valid); end
    issue(1'b0, 32'h100, 32'h0, 2'd2);
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL load_rsp_valid: got %b want 1", rsp_valid); end
    n_checks++; if (rsp_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_rsp_data: got %h want %h", rsp_data, 32'hDEADBEEF); end
    @(posedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL load_consumed: got %b want 0", rsp_valid); end
  endtask

  task automatic test_byte_merge();
    do_reset();
    issue(1'b1, 32'h102, 32'h00AA0000, 2'd0);
    free_data = 32'h11223344;
    issue(1'b0, 32'h100, 32'h0, 2'd2);
    n_checks++; if (rsp_data !== 32'h11AA3344) begin n_fail++; $display("FAIL byte_merge: got %h want %h", rsp_data, 32'h11AA3344); end
    issue(1'b0, 32'h200, 32'h0, 2'd2);
    n_checks++; if (rsp_data !== 32'h11223344) begin n_fail++; $display("FAIL unwritten_slot1: got %h want %h", rsp_data, 32'h11223344); end
    free_data = 32'h55667788;
    issue(1'b0, 32'h300, 32'h0, 2'd2);
    n_checks++; if (rsp_data !== 32'h55667788) begin n_fail++; $display("FAIL untracked_free: got %h want %h", rsp_data, 32'h55667788); end
    @(posedge clk); #1;
  endtask

  task automatic test_hold_snapshot();
    free_data = 32'h0;
    rsp_hold  = 1'b1;
    issue(1'b1, 32'h100, 32'h00000001, 2'd2);
    issue(1'b0, 32'h100, 32'h0, 2'd2);
    issue(1'b1, 32'h100, 32'h00000002, 2'd2);
    @(posedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL hold_rsp_valid: got %b want 0", rsp_valid); end
    rsp_hold = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL release_rsp_valid: got %b want 1", rsp_valid); end
    n_checks++; if (rsp_data !== 32'h00000001) begin n_fail++; $display("FAIL snapshot_data: got %h want %h", rsp_data, 32'h1); end
    @(posedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL snapshot_consumed: got %b want 0", rsp_valid); end
    issue(1'b0, 32'h100, 32'h0, 2'd2);
    n_checks++; if (rsp_data !== 32'h00000002) begin n_fail++; $display("FAIL second_store_data: got %h want %h", rsp_data, 32'h2); end
    @(posedge clk); #1;
  endtask

  task automatic test_fifo_full();
    rsp_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      free_data = 32'hA000_0000 + 32'(i);
      issue(1'b0, 32'h300, 32'h0, 2'd2);
    end
    n_checks++; if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL fifo_full: got %b want 1", fifo_full); end
    @(negedge clk);
    free_data   = 32'hBAD0BAD0;
    cmd_valid   = 1'b1;
    cmd_wr      = 1'b0;
    cmd_address = 32'h300;
    cmd_size    = 2'd2;
    #1;
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL full_load_ready: got %b want 0", cmd_ready); end
    @(posedge clk); #1;
    cmd_wr      = 1'b1;
    cmd_address = 32'h200;
    cmd_data    = 32'h00000055;
    #1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL full_store_ready: got %b want 1", cmd_ready); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
    rsp_hold  = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid: got %b want 1", rsp_valid); end
    n_checks++; if (rsp_data !== 32'hA0000000) begin n_fail++; $display("FAIL drain_0: got %h want %h", rsp_data, 32'hA0000000); end
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      n_checks++; if (rsp_data !== 32'hA000_0000 + 32'(i)) begin n_fail++; $display("FAIL drain_%0d: got %h want %h", i, rsp_data, 32'hA000_0000 + 32'(i)); end
    end
    @(posedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %b want 0", rsp_valid); end
    free_data = 32'h0;
    issue(1'b0, 32'h200, 32'h0, 2'd2);
    n_checks++; if (rsp_data !== 32'h00000055) begin n_fail++; $display("FAIL full_store_landed: got %h want %h", rsp_data, 32'h55); end
    @(posedge clk); #1;
  endtask

  task automatic test_misaligned();
    do_reset();
    issue(1'b1, 32'h103, 32'hCC000000, 2'd1);
    n_checks++; if (cmd_misaligned !== 1'b1) begin n_fail++; $display("FAIL misaligned_set: got %b want 1", cmd_misaligned); end
    free_data = 32'h11223344;
    issue(1'b0, 32'h100, 32'h0, 2'd2);
    n_checks++; if (cmd_misaligned !== 1'b0) begin n_fail++; $display("FAIL misaligned_clear: got %b want 0", cmd_misaligned); end
    n_checks++; if (rsp_data !== 32'hCC223344) begin n_fail++; $display("FAIL misaligned_bytes: got %h want %h", rsp_data, 32'hCC223344); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    free_data = 32'h0;
    issue(1'b1, 32'h100, 32'h12345678, 2'd2);
    rsp_hold = 1'b1;
    issue(1'b0, 32'h100, 32'h0, 2'd2);
    issue(1'b0, 32'h100, 32'h0, 2'd2);
    @(negedge clk);
    resetn   = 1'b0;
    rsp_hold = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_rsp_valid: got %b want 0", rsp_valid); end
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_dropped: got %b want 0", rsp_valid); end
    free_data = 32'h99887766;
    issue(1'b0, 32'h100, 32'h0, 2'd2);
    n_checks++; if (rsp_data !== 32'h99887766) begin n_fail++; $display("FAIL midreset_shadow_lost: got %h want %h", rsp_data, 32'h99887766); end
    @(posedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_final_empty: got %b want 0", rsp_valid); end
  endtask

  initial begin
    resetn      = 1'b0;
    slot_addr   = {32'h0000_0200, 32'h0000_0100};
    cmd_valid   = 1'b0;
    cmd_wr      = 1'b0;
    cmd_address = '0;
    cmd_data    = '0;
    cmd_size    = 2'd2;
    cmd_stall   = 1'b0;
    rsp_hold    = 1'b0;
    free_data   = '0;
    test_reset();
    test_store_load();
    test_byte_merge();
    test_hold_snapshot();
    test_fifo_full();
    test_misaligned();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
